camera_frame_rx: RTL
====================

// Module: camera_frame_rx
// PURPOSE
//  Receiving end of the parallel camera bus (frame_valid / line_valid / pixel_data).
//  Samples pixels, tags start-of-frame and end-of-line, checks frame geometry, and
//  buffers pixels into a FIFO drained by a valid/ready consumer (histogram pipeline).
//  The camera cannot be stalled, so FIFO overflow drops pixels and is flagged.
// PARAMETERS
//  WIDTH       1920  expected pixels per line
//  HEIGHT      1280  expected lines per frame
//  PIX_W       10    pixel data width
//  FIFO_DEPTH  16    output FIFO entries, power of 2, >= 4
//  CNT_W       16    width of pixel/line counters; counters saturate at all-ones
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  en           in   1      capture enable, level; sampled only at frame boundaries
//  frame_valid  in   1      camera frame sync, high for whole frame
//  line_valid   in   1      camera line sync, high while pixel_data is valid
//  pixel_data   in   PIX_W  camera pixel
//  out_ready    in   1      consumer accepts out_data when out_valid & out_ready
//  out_valid    out  1      FIFO head valid (first-word-fall-through)
//  out_data     out  PIX_W  pixel at FIFO head
//  out_sof      out  1      head is first pixel of a frame
//  out_eol      out  1      head is last pixel of a line
//  frame_done   out  1      one-cycle pulse when a captured frame ends
//  frame_ok     out  1      valid with frame_done: geometry correct and no overflow
//  err_width    out  1      sticky per frame: some line length != WIDTH
//  err_height   out  1      sticky per frame: line count != HEIGHT (set at frame end)
//  overflow     out  1      sticky per frame: >=1 pixel dropped on full FIFO
//  frame_count  out  16     captured frames completed, wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, counters 0, state IDLE; applies mid-line too.
//  Inputs registered once (fv_q, lv_q, pix_q) before any decision.
//  FSM: IDLE -> ARMED when en=1 and fv_q=0 (never arm mid-frame).
//   ARMED -> FRAME on fv_q rising; clears err_width/err_height/overflow, line cnt=0.
//   FRAME -> LINE on lv_q rising (same-cycle fv/lv rise allowed); pixel cnt=0.
//   LINE  -> FRAME on lv_q falling: line cnt+1; err_width if pixel cnt != WIDTH.
//   FRAME/LINE -> on fv_q falling: err_height if line cnt != HEIGHT; frame_done=1
//    next cycle, frame_ok = !(err_width|err_height|overflow) incl. this cycle's
//    updates; frame_count+1; go ARMED if en=1 else IDLE.
//   fv_q and lv_q falling together: close line first, then frame, same cycle.
//  lv_q high while fv_q low: ignored, no pixels written, no error.
//  en=0 mid-frame: current frame completes normally, then IDLE.
//  Pixels: one-entry hold stage so eol is known; held pixel written to FIFO when
//   next pixel arrives (eol=0) or lv_q falls (eol=1). sof=1 on first pixel of frame.
//   Pixel-to-out_valid latency: 3 cycles minimum (input reg, hold, FIFO write).
//  FIFO entry = {sof, eol, data}; write when full -> entry dropped, overflow=1;
//   simultaneous read+write when full: read frees slot, write succeeds.
//  out_data/out_sof/out_eol held stable while out_valid & !out_ready.
//  Pixel/line counters saturate at 2^CNT_W-1 (still compared, so error set).
// STRUCTURE
//  Shared package cam_pkg: PIX_W default, FSM state enum {IDLE,ARMED,FRAME,LINE},
//   FIFO entry struct {sof, eol, data}.
//  One sub-module: cam_sync_fifo (synchronous FWFT FIFO, full/empty, depth param).
//  Top holds input regs, FSM, counters, hold stage, status flags.
// TESTING (bench uses WIDTH=8, HEIGHT=4, FIFO_DEPTH=16, out_ready=1 unless noted)
//  1 en=1, 4 lines x 8 px, pixel = 8*line+px -> 32 outputs 0..31 in order, out_sof
//    only on 0, out_eol on 7,15,23,31; frame_done pulse, frame_ok=1, frame_count=1.
//  2 Line 2 has 7 px -> err_width=1, frame_ok=0; next clean frame clears it, ok=1.
//  3 Frame with 5 lines -> err_height=1, frame_ok=0, all 40 pixels still output.
//  4 out_ready=0 for whole 32-px frame -> 16 entries kept (pixels 0..15),
//    overflow=1, frame_ok=0; then out_ready=1 drains exactly 16 entries.
//  5 en rises mid-frame -> that frame produces no output/frame_done; next frame
//    captured with frame_count=1.
//  6 rst_n low mid-line 2 for 1 cycle -> all outputs 0, FIFO empty; next full
//    frame with en=1 captured with frame_ok=1.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types for the camera receive path.
//   CAM_PIX_W   : default pixel width; also sizes the FIFO entry struct
//   cam_state_e : capture FSM states
//   cam_entry_t : one FIFO word {sof, eol, data}
package cam_pkg;

  localparam int CAM_PIX_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FRAME = 2'd2,
    LINE  = 2'd3
  } cam_state_e;

  typedef struct packed {
    logic                 sof;
    logic                 eol;
    logic [CAM_PIX_W-1:0] data;
  } cam_entry_t;

endpackage

// File: rtl/camera_frame_rx_if.sv
// Pixel output stream of camera_frame_rx (valid/ready, first-word-fall-through).
//   out_valid : head entry present
//   out_ready : consumer takes head when out_valid & out_ready
//   out_data  : pixel at head
//   out_sof   : head is first pixel of a frame
//   out_eol   : head is last pixel of a line
// master = producer (receiver), slave = consumer.
interface camera_frame_rx_if #(
  parameter int PIX_W = cam_pkg::CAM_PIX_W
);
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_sof;
  logic             out_eol;

  modport master (output out_valid, out_data, out_sof, out_eol, input  out_ready);
  modport slave  (input  out_valid, out_data, out_sof, out_eol, output out_ready);
endinterface

// File: rtl/cam_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, async active-low reset (pointers only)
//   wr_en      : write request; taken if not full, or if a read frees a slot
//   wr_data    : write word
//   rd_en      : pop head (ignored when empty)
//   rd_data    : head word, valid whenever !empty
//   full/empty : occupancy flags
// DEPTH must be a power of two.
module cam_sync_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         wr_go, rd_go;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    rd_go    = rd_en & ~empty;
    wr_go    = wr_en & (~full | rd_go);
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_go);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_go);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/camera_frame_rx.sv
// Parallel camera bus receiver.
// Samples frame_valid/line_valid/pixel_data, tags sof/eol, checks frame
// geometry, and buffers pixels in a FIFO for a valid/ready consumer. The
// camera cannot be stalled: writes into a full FIFO are dropped and flagged.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   en              : capture enable, acted on only between frames
//   frame_valid     : camera frame sync
//   line_valid      : camera line sync / pixel qualifier
//   pixel_data      : camera pixel
//   out_if          : pixel stream (master side)
//   frame_done      : 1-cycle pulse after a captured frame ends
//   frame_ok        : result of the last captured frame, valid with frame_done
//   err_width       : sticky per frame, some line length != WIDTH
//   err_height      : sticky per frame, line count != HEIGHT
//   overflow        : sticky per frame, a pixel was dropped
//   frame_count     : completed captured frames, wrapping
// PIX_W must equal CAM_PIX_W: FIFO entries use the package struct.
module camera_frame_rx
  import cam_pkg::*;
#(
  parameter int WIDTH      = 1920,
  parameter int HEIGHT     = 1280,
  parameter int PIX_W      = CAM_PIX_W,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              frame_valid,
  input  logic              line_valid,
  input  logic [PIX_W-1:0]  pixel_data,
  camera_frame_rx_if.master out_if,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              err_width,
  output logic              err_height,
  output logic              overflow,
  output logic [15:0]       frame_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Input sampling
  logic             inp_vld_q;   // fv_q/lv_q hold real samples (not reset values)
  logic             fv_q, lv_q, lv_prev_q;
  logic [PIX_W-1:0] pix_q;

  cam_state_e       state_q, state_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d, pix_cnt_q, pix_cnt_d;
  logic             sof_pend_q, sof_pend_d;
  logic             hold_vld_q, hold_vld_d;
  cam_entry_t       hold_q, hold_d;
  logic             err_width_q, err_width_d, err_height_q, err_height_d;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic [15:0]      frame_count_q, frame_count_d;

  logic             lv_rise, frame_start, line_start, line_end, frame_end, pix_take;
  logic             fifo_wr, fifo_full, fifo_empty, rd_fire;
  cam_entry_t       fifo_wdata, fifo_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inp_vld_q <= 1'b0;
      fv_q      <= 1'b0;
      lv_q      <= 1'b0;
      lv_prev_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      inp_vld_q <= 1'b1;
      fv_q      <= frame_valid;
      lv_q      <= line_valid;
      lv_prev_q <= lv_q;
      pix_q     <= pixel_data;
    end
  end

  // Event decode, shared by FSM and datapath
  assign lv_rise     = lv_q & ~lv_prev_q;
  assign frame_start = (state_q == ARMED) & en & fv_q;
  assign line_start  = fv_q & lv_rise & (frame_start | (state_q == FRAME));
  // A line also closes if the frame drops while line_valid is still high.
  assign line_end    = (state_q == LINE) & (~lv_q | ~fv_q);
  assign frame_end   = ((state_q == FRAME) | (state_q == LINE)) & ~fv_q;
  assign pix_take    = fv_q & lv_q & (line_start | (state_q == LINE));
  assign rd_fire     = out_if.out_ready & ~fifo_empty;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (en && inp_vld_q && !fv_q) state_d = ARMED;
      // Dropping en while armed disarms; a frame starting then is ignored.
      ARMED: if (!en)      state_d = IDLE;
             else if (fv_q) state_d = lv_rise ? LINE : FRAME;
      FRAME: if (!fv_q)        state_d = en ? ARMED : IDLE;
             else if (lv_rise) state_d = LINE;
      LINE:  if (!fv_q)        state_d = en ? ARMED : IDLE;
             else if (!lv_q)   state_d = FRAME;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs / datapath
  always_comb begin
    line_cnt_d    = line_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    sof_pend_d    = sof_pend_q;
    hold_vld_d    = hold_vld_q;
    hold_d        = hold_q;
    err_width_d   = err_width_q;
    err_height_d  = err_height_q;
    overflow_d    = overflow_q;
    frame_done_d  = 1'b0;
    frame_ok_d    = frame_ok_q;
    frame_count_d = frame_count_q;
    fifo_wr       = 1'b0;
    fifo_wdata    = hold_q;

    if (frame_start) begin
      err_width_d  = 1'b0;
      err_height_d = 1'b0;
      overflow_d   = 1'b0;
      line_cnt_d   = '0;
      sof_pend_d   = 1'b1;
    end

    // The held pixel is only known not to end its line once a successor arrives.
    if (pix_take) begin
      if (hold_vld_q) begin
        fifo_wr        = 1'b1;
        fifo_wdata.eol = 1'b0;
      end
      hold_d.sof  = sof_pend_d;
      hold_d.eol  = 1'b0;
      hold_d.data = pix_q;
      hold_vld_d  = 1'b1;
      sof_pend_d  = 1'b0;
      pix_cnt_d   = line_start ? CNT_W'(1) : sat_inc(pix_cnt_q);
    end

    if (line_end) begin
      if (hold_vld_q) begin
        fifo_wr        = 1'b1;
        fifo_wdata.eol = 1'b1;
      end
      hold_vld_d = 1'b0;
      line_cnt_d = sat_inc(line_cnt_q);
      if (pix_cnt_q != CNT_W'(WIDTH)) err_width_d = 1'b1;
    end

    if (fifo_wr && fifo_full && !rd_fire) overflow_d = 1'b1;

    // Line close above is folded in before the frame verdict.
    if (frame_end) begin
      if (line_cnt_d != CNT_W'(HEIGHT)) err_height_d = 1'b1;
      frame_done_d  = 1'b1;
      frame_ok_d    = ~(err_width_d | err_height_d | overflow_d);
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      sof_pend_q    <= 1'b0;
      hold_vld_q    <= 1'b0;
      hold_q        <= '0;
      err_width_q   <= 1'b0;
      err_height_q  <= 1'b0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      line_cnt_q    <= line_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      sof_pend_q    <= sof_pend_d;
      hold_vld_q    <= hold_vld_d;
      hold_q        <= hold_d;
      err_width_q   <= err_width_d;
      err_height_q  <= err_height_d;
      overflow_q    <= overflow_d;
      frame_done_q  <= frame_done_d;
      frame_ok_q    <= frame_ok_d;
      frame_count_q <= frame_count_d;
    end
  end

  cam_sync_fifo #(
    .W     ($bits(cam_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (out_if.out_ready),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head is forced to zero when empty so outputs are clean out of reset.
  assign out_if.out_valid = ~fifo_empty;
  assign out_if.out_data  = fifo_empty ? '0   : fifo_rdata.data;
  assign out_if.out_sof   = fifo_empty ? 1'b0 : fifo_rdata.sof;
  assign out_if.out_eol   = fifo_empty ? 1'b0 : fifo_rdata.eol;

  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign err_width   = err_width_q;
  assign err_height  = err_height_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule
